// File: rtl/soc_mgmt_syscfg_apb_arb.sv
// Two-manager round-robin APB arbiter feeding the shared syscfg subordinate port.
// Optional macro SOC_MGMT_SYSCFG_APB_ARB_TIMEOUT_EN adds an ACCESS-phase timeout that completes with an error.
module soc_mgmt_syscfg_apb_arb #(
    parameter int PAW            = 19,
    parameter int PDW            = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [1:0]              i_m_psel,
    input  logic [1:0]              i_m_penable,
    input  logic [1:0]              i_m_pwrite,
    input  logic [1:0][PAW-1:0]     i_m_paddr,
    input  logic [1:0][PDW-1:0]     i_m_pwdata,
    input  logic [1:0][PDW/8-1:0]   i_m_pstrb,
    output logic [1:0]              o_m_pready,
    output logic [1:0]              o_m_pslverr,
    output logic [1:0][PDW-1:0]     o_m_prdata,
    output logic                    o_s_psel,
    output logic                    o_s_penable,
    output logic                    o_s_pwrite,
    output logic [PAW-1:0]          o_s_paddr,
    output logic [PDW-1:0]          o_s_pwdata,
    output logic [PDW/8-1:0]        o_s_pstrb,
    input  logic                    i_s_pready,
    input  logic                    i_s_pslverr,
    input  logic [PDW-1:0]          i_s_prdata,
    output logic [1:0]              o_dbg_state
);

    localparam int          SW      = PDW / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e         state_q;
    logic           gnt_q;
    logic           last_q;
    logic           win_d;
    logic           psel_q;
    logic           penable_q;
    logic           pwrite_q;
    logic [PAW-1:0] paddr_q;
    logic [PDW-1:0] pwdata_q;
    logic [SW-1:0]  pstrb_q;
    logic           xfer_ok;
    logic           timeout_hit;
    logic           xfer_done;
    logic           unused_penable;

    // Manager penable only qualifies the manager's own phase; the grant is taken from psel alone.
    assign unused_penable = ^i_m_penable;

    // Contention goes to the manager that was not granted last; a lone requester always wins.
    always_comb begin
        win_d = 1'b0;
        if (i_m_psel == 2'b11) begin
            win_d = ~last_q;
        end else if (i_m_psel[1]) begin
            win_d = 1'b1;
        end
    end

    assign xfer_ok = (state_q == ST_ACCESS) && i_s_pready;

`ifdef SOC_MGMT_SYSCFG_APB_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_q;

    // Counts ACCESS cycles without pready; a pready in the final cycle still wins.
    assign timeout_hit = (state_q == ST_ACCESS) && !i_s_pready && (to_cnt_q == TO_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            to_cnt_q <= '0;
        end else if ((state_q == ST_ACCESS) && !i_s_pready) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TO_LAST;
`endif

    assign xfer_done = xfer_ok | timeout_hit;

    // Handshake: a transfer completes in the single ACCESS cycle where the subordinate
    // (or the timeout) signals ready; only the granted manager sees pready/pslverr/prdata,
    // and only while it still holds psel, so an abandoned request gets no response.
    always_comb begin
        o_m_pready  = '0;
        o_m_pslverr = '0;
        o_m_prdata  = '0;
        if (xfer_done && i_m_psel[gnt_q]) begin
            o_m_pready[gnt_q]  = 1'b1;
            o_m_pslverr[gnt_q] = timeout_hit | i_s_pslverr;
            o_m_prdata[gnt_q]  = xfer_ok ? i_s_prdata : '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|i_m_psel) begin
                        state_q   <= ST_SETUP;
                        gnt_q     <= win_d;
                        last_q    <= win_d;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= i_m_pwrite[win_d];
                        paddr_q   <= i_m_paddr[win_d];
                        pwdata_q  <= i_m_pwdata[win_d];
                        pstrb_q   <= i_m_pstrb[win_d];
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end
                ST_ACCESS: begin
                    if (xfer_done) begin
                        state_q   <= ST_IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_s_psel    = psel_q;
    assign o_s_penable = penable_q;
    assign o_s_pwrite  = pwrite_q;
    assign o_s_paddr   = paddr_q;
    assign o_s_pwdata  = pwdata_q;
    assign o_s_pstrb   = pstrb_q;
    assign o_dbg_state = state_q;

endmodule
